// File: rtl/microondas_pkg.sv
// microondas_pkg: shared state encodings and mux-select codes for the microwave controller
package microondas_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } estado_t;
  localparam logic SEL_TECLADO  = 1'b0;
  localparam logic SEL_CONTAGEM = 1'b1;
endpackage

// File: rtl/contador_espera.sv
// contador_espera: loadable down-counter that stops at zero and flags terminal count
module contador_espera #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carga,
  input  logic             en,
  input  logic [CNT_W-1:0] valor,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  // load has priority; counting saturates at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (carga) cnt <= valor;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/seletor_ctrl.sv
// seletor_ctrl: microwave phase sequencer driving the display mux select (option: SEL_BLANK_EN adds display blanking)
module seletor_ctrl
  import microondas_pkg::*;
#(
  parameter int DONE_CYC  = 8,
  parameter int BLANK_CYC = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tecla_valida,
  input  logic       start,
  input  logic       parar,
  input  logic       porta_aberta,
  input  logic       zero,
  output logic       seletor,
  output logic       carrega,
  output logic       limpa,
  output logic       conta_en,
  output logic       magnetron,
  output logic       fim,
  output logic       apagar,
  output logic [2:0] estado
);
  localparam int HOLD_MAX = DONE_CYC > BLANK_CYC ? DONE_CYC : BLANK_CYC;
  if (HOLD_MAX > (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow for hold counts");
  end
  logic [2:0] st, nx;
  logic sel_nx, car_nx, lim_nx, cen_nx, mag_nx, fim_nx;
  logic done_tc, done_load;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nx;
  // next state; carrega marks the first COOK cycle, where zero is not yet meaningful
  always_comb begin
    nx = IDLE;
    case (st)
      IDLE:    nx = tecla_valida ? ENTRY : IDLE;
      ENTRY:   nx = parar ? IDLE : (start && !porta_aberta) ? COOK : ENTRY;
      COOK:    nx = (zero && !carrega) ? DONE : (porta_aberta || parar) ? PAUSE : COOK;
      PAUSE:   nx = parar ? IDLE : (start && zero) ? DONE : (start && !porta_aberta) ? COOK : PAUSE;
      DONE:    nx = (parar || done_tc) ? IDLE : DONE;
      default: nx = IDLE;
    endcase
  end
  // next-cycle output values derived from the transition being taken
  always_comb begin
    sel_nx    = (nx == COOK || nx == PAUSE || nx == DONE) ? SEL_CONTAGEM : SEL_TECLADO;
    car_nx    = st == ENTRY && nx == COOK;
    lim_nx    = nx == IDLE && (st == ENTRY || st == PAUSE || st == DONE);
    cen_nx    = nx == COOK && st != ENTRY;
    mag_nx    = nx == COOK;
    fim_nx    = nx == DONE;
    done_load = nx == DONE && st != DONE;
  end
  // registered Moore outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {seletor, carrega, limpa, conta_en, magnetron, fim} <= '0;
    else {seletor, carrega, limpa, conta_en, magnetron, fim} <= {sel_nx, car_nx, lim_nx, cen_nx, mag_nx, fim_nx};
  assign estado = st;
  contador_espera #(.CNT_W(CNT_W)) u_done (
    .clk(clk), .rst_n(rst_n), .carga(done_load), .en(st == DONE),
    .valor(CNT_W'(DONE_CYC - 1)), .tc(done_tc)
  );
`ifdef SEL_BLANK_EN
  logic troca, blank_tc;
  assign troca = sel_nx != seletor;
  contador_espera #(.CNT_W(CNT_W)) u_blank (
    .clk(clk), .rst_n(rst_n), .carga(troca), .en(apagar),
    .valor(CNT_W'(BLANK_CYC - 1)), .tc(blank_tc)
  );
  // blank on every select change, retriggering if another change lands mid-blank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) apagar <= 1'b0;
    else apagar <= troca || (apagar && !blank_tc);
`else
  assign apagar = 1'b0;
`endif
endmodule

// File: tb/tb_seletor_ctrl.sv
// tb_seletor_ctrl: scoreboard bench for seletor_ctrl
module tb_seletor_ctrl;
  logic clk = 0, rst_n = 0;
  logic tecla_valida = 0, start = 0, parar = 0, porta_aberta = 0, zero = 0;
  logic seletor, carrega, limpa, conta_en, magnetron, fim, apagar;
  logic [2:0] estado;
  int checks = 0, errors = 0;
  logic [9:0] sb[$];
  wire [9:0] obs = {estado, seletor, carrega, limpa, conta_en, magnetron, fim, apagar};
  always #5 clk = ~clk;
  seletor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tecla_valida(tecla_valida), .start(start), .parar(parar),
    .porta_aberta(porta_aberta), .zero(zero), .seletor(seletor), .carrega(carrega),
    .limpa(limpa), .conta_en(conta_en), .magnetron(magnetron), .fim(fim),
    .apagar(apagar), .estado(estado)
  );
  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d flags=%b, expected st=%0d flags=%b", tag, got[9:7], got[6:0], exp[9:7], exp[6:0]);
    end
  endtask
  // flags: seletor carrega limpa conta_en magnetron fim apagar
  function automatic logic [9:0] ev(input logic [2:0] s, input logic [6:0] f);
    logic [6:0] g;
    g = f;
`ifndef SEL_BLANK_EN
    g[0] = 1'b0;
`endif
    return {s, g};
  endfunction
  // inputs: tecla_valida start parar porta_aberta zero
  task automatic step(input string tag, input logic [4:0] in, input logic [2:0] s, input logic [6:0] f);
    @(negedge clk);
    {tecla_valida, start, parar, porta_aberta, zero} = in;
    sb.push_back(ev(s, f));
    @(posedge clk);
    #1;
    chk(tag, obs, sb.pop_front());
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset", obs, 10'd0);
    @(negedge clk) rst_n = 1;
    step("idle_start",    5'b01000, 0, 7'b0000000);
    step("idle_tecla",    5'b10000, 1, 7'b0000000);
    step("entry_dooropen",5'b01010, 1, 7'b0000000);
    step("cook_first",    5'b01000, 2, 7'b1100101);
    step("cook_zero_ign", 5'b00001, 2, 7'b1001101);
    step("cook_run",      5'b00000, 2, 7'b1001100);
    step("done_enter",    5'b00001, 4, 7'b1000010);
    for (int i = 0; i < 7; i++) step("done_hold", 5'b11001, 4, 7'b1000010);
    step("done_exit",     5'b00000, 0, 7'b0010001);
    step("idle_blank2",   5'b00000, 0, 7'b0000001);
    step("idle_quiet",    5'b00000, 0, 7'b0000000);
    step("door_entry",    5'b10000, 1, 7'b0000000);
    step("door_cook",     5'b01000, 2, 7'b1100101);
    step("door_pause",    5'b00010, 3, 7'b1000001);
    step("pause_open_st", 5'b01010, 3, 7'b1000000);
    step("pause_resume",  5'b01000, 2, 7'b1001100);
    step("zero_and_door", 5'b00011, 4, 7'b1000010);
    step("done_parar",    5'b00100, 0, 7'b0010001);
    step("idle_b2",       5'b00000, 0, 7'b0000001);
    step("idle_q2",       5'b00000, 0, 7'b0000000);
    step("sim_entry",     5'b10000, 1, 7'b0000000);
    step("sim_cook",      5'b01000, 2, 7'b1100101);
    step("sim_pause",     5'b00100, 3, 7'b1000001);
    step("pause_par_st",  5'b01100, 0, 7'b0010001);
    step("idle_b3",       5'b00000, 0, 7'b0000001);
    step("idle_q3",       5'b00000, 0, 7'b0000000);
    step("ep_entry",      5'b10000, 1, 7'b0000000);
    step("entry_parar",   5'b01100, 0, 7'b0010000);
    step("pz_entry",      5'b10000, 1, 7'b0000000);
    step("pz_cook",       5'b01000, 2, 7'b1100101);
    step("pz_pause",      5'b00010, 3, 7'b1000001);
    step("pause_st_zero", 5'b01011, 4, 7'b1000010);
    step("pz_parar",      5'b00100, 0, 7'b0010001);
    step("idle_b4",       5'b00000, 0, 7'b0000001);
    step("rc_entry",      5'b10000, 1, 7'b0000000);
    step("rc_cook",       5'b01000, 2, 7'b1100101);
    step("rc_run",        5'b00000, 2, 7'b1001101);
    rst_n = 0;
    #1 chk("rst_async", obs, 10'd0);
    @(negedge clk) rst_n = 1;
    step("post_reset",    5'b00000, 0, 7'b0000000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
